// File: rtl/tc0480scp_rom_cache_pkg.sv
// Shared types and sizing for the TC0480SCP tilemap gfx ROM cache.
// Address geometry: 21-bit byte address and 64-bit lines. Tag = address bits above index.
package tc0480scp_rom_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL,
    ST_RESPOND
  } cache_state_t;

  localparam int CACHE_BITS_DEF = 6;
  localparam int ROM_AW         = 21;
  localparam int SDR_AW         = 27;
  localparam int LINE_W         = 64;
  localparam int TAG_W          = ROM_AW - 3 - CACHE_BITS_DEF;

  function automatic int tag_width(input int cache_bits);
    return ROM_AW - 3 - cache_bits;
  endfunction

endpackage

// File: rtl/tc0480scp_cache_ram.sv
// Single-port synchronous RAM holding {tag, line} per cache entry, registered read.
module tc0480scp_cache_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 76
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; validity lives in a separate flop vector.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tc0480scp_rom_cache.sv
// Direct-mapped read cache between the TC0480SCP gfx ROM port and SDRAM.
// Both sides use toggle handshakes; one request is in flight at a time.
module tc0480scp_rom_cache
  import tc0480scp_rom_cache_pkg::*;
#(
  parameter logic [SDR_AW-1:0] SDR_BASE   = 27'h0,
  parameter int                CACHE_BITS = CACHE_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ROM_AW-1:0] rom_address,
  input  logic              rom_req,
  output logic [LINE_W-1:0] rom_data,
  output logic              rom_ack,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic              sdr_req,
  input  logic [LINE_W-1:0] sdr_data,
  input  logic              sdr_ack
);

  localparam int TW    = tag_width(CACHE_BITS);
  localparam int RAM_W = TW + LINE_W;
  localparam int DEPTH = 2**CACHE_BITS;

  cache_state_t        r_state;
  logic [ROM_AW-1:3]   r_line_addr;
  logic [LINE_W-1:0]   r_rom_data;
  logic                r_rom_ack;
  logic [SDR_AW-1:0]   r_sdr_addr;
  logic                r_sdr_req;
  logic [DEPTH-1:0]    r_valid;
  logic                r_fill_flushed;

  logic [CACHE_BITS-1:0] w_index_in;
  logic [CACHE_BITS-1:0] w_index;
  logic [TW-1:0]         w_tag;
  logic [CACHE_BITS-1:0] w_ram_addr;
  logic [RAM_W-1:0]      w_ram_rdata;
  logic [RAM_W-1:0]      w_ram_wdata;
  logic                  w_ram_we;
  logic                  w_pending;
  logic                  w_fill_done;
  logic                  w_hit;
  logic [SDR_AW-1:0]     w_sdr_addr;
  logic                  w_unused_ok;

  assign w_index_in  = rom_address[CACHE_BITS+2:3];
  assign w_index     = r_line_addr[CACHE_BITS+2:3];
  assign w_tag       = r_line_addr[ROM_AW-1:CACHE_BITS+3];
  assign w_pending   = (rom_req != r_rom_ack);
  assign w_fill_done = (r_state == ST_FILL) && (sdr_ack == r_sdr_req);
  assign w_unused_ok = ^rom_address[2:0];

  // The RAM read is launched from the live address in IDLE so the tag is ready in LOOKUP.
  assign w_ram_addr  = (r_state == ST_IDLE) ? w_index_in : w_index;
  assign w_ram_we    = w_fill_done && !reset;
  assign w_ram_wdata = {w_tag, sdr_data};

  // A flush in the compare cycle must win over a matching tag.
  assign w_hit = r_valid[w_index] && (w_ram_rdata[RAM_W-1:LINE_W] == w_tag) && !flush;

  assign w_sdr_addr = SDR_BASE + {{(SDR_AW-ROM_AW){1'b0}}, r_line_addr, 3'b000};

  tc0480scp_cache_ram #(
    .ADDR_W (CACHE_BITS),
    .DATA_W (RAM_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_line_addr    <= '0;
      r_rom_data     <= '0;
      r_rom_ack      <= 1'b0;
      r_sdr_addr     <= '0;
      r_sdr_req      <= 1'b0;
      r_fill_flushed <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_line_addr <= rom_address[ROM_AW-1:3];
            r_state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_rom_data <= w_ram_rdata[LINE_W-1:0];
            r_state    <= ST_RESPOND;
          end else begin
            r_sdr_addr     <= w_sdr_addr;
            r_sdr_req      <= ~r_sdr_req;
            r_fill_flushed <= 1'b0;
            r_state        <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (flush) r_fill_flushed <= 1'b1;
          if (w_fill_done) begin
            r_rom_data <= sdr_data;
            r_state    <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          r_rom_ack <= ~r_rom_ack;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // A fill that saw a flush while outstanding still writes the RAM but stays invalid.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= '0;
    end else if (w_fill_done && !r_fill_flushed) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  assign rom_data = r_rom_data;
  assign rom_ack  = r_rom_ack;
  assign sdr_addr = r_sdr_addr;
  assign sdr_req  = r_sdr_req;

endmodule

// File: tb/tb_tc0480scp_rom_cache.sv
// Self-checking bench: directed scenarios plus random traffic against a line-level cache model.
module tb_tc0480scp_rom_cache;

  localparam logic [26:0] SDR_BASE = 27'h7F00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [20:0] rom_address = '0;
  logic        rom_req = 1'b0;
  logic [63:0] rom_data;
  logic        rom_ack;
  logic [26:0] sdr_addr;
  logic        sdr_req;
  logic [63:0] sdr_data = '0;
  logic        sdr_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // SDRAM responder state
  logic        sdr_hold = 1'b0;
  logic        fixed_en = 1'b0;
  logic [63:0] fixed_data = 64'hDEADBEEF01234567;
  logic        seen_req = 1'b0;
  int          wait_cnt = 0;
  int          sdr_count = 0;
  logic [26:0] cap_addr = '0;
  logic [63:0] last_sdr_data = '0;

  // Reference model: one entry per cache index
  bit          m_valid [64];
  int          m_tag   [64];
  logic [63:0] m_data  [64];

  tc0480scp_rom_cache #(
    .SDR_BASE   (SDR_BASE),
    .CACHE_BITS (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .rom_address (rom_address),
    .rom_req     (rom_req),
    .rom_data    (rom_data),
    .rom_ack     (rom_ack),
    .sdr_addr    (sdr_addr),
    .sdr_req     (sdr_req),
    .sdr_data    (sdr_data),
    .sdr_ack     (sdr_ack)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        sdr_ack  = 1'b0;
        seen_req = 1'b0;
      end else begin
        if (sdr_req !== seen_req) begin
          seen_req = sdr_req;
          sdr_count++;
          cap_addr = sdr_addr;
          wait_cnt = $urandom_range(0, 4);
        end
        if (sdr_req !== sdr_ack && !sdr_hold) begin
          if (wait_cnt == 0) begin
            sdr_data      = fixed_en ? fixed_data : {$urandom, $urandom};
            last_sdr_data = sdr_data;
            sdr_ack       = sdr_req;
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  // fmode: 0 plain, 1 flush in the compare cycle, 2 flush while the SDRAM fetch is outstanding
  task automatic do_req(input logic [20:0] addr, input int fmode, input string name);
    int          idx, tg, cyc, sdr_before;
    logic        exp_hit;
    logic [63:0] exp_data;
    logic [26:0] exp_sdr;
    idx = int'((addr >> 3) % 64);
    tg  = int'(addr >> 9);
    exp_hit    = m_valid[idx] && (m_tag[idx] == tg) && (fmode != 1);
    exp_sdr    = SDR_BASE + {6'd0, addr[20:3], 3'b000};
    sdr_before = sdr_count;
    if (fmode == 2) sdr_hold = 1'b1;
    @(posedge clk); #1;
    rom_address = addr;
    rom_req     = ~rom_req;
    cyc = 0;
    while (rom_ack !== rom_req && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      flush = ((fmode == 1) && (cyc == 1)) || ((fmode == 2) && (cyc == 3));
      if (fmode == 2 && cyc == 5) sdr_hold = 1'b0;
    end
    flush    = 1'b0;
    sdr_hold = 1'b0;
    check({name, "_ack"}, 64'(rom_ack), 64'(rom_req));
    if (fmode != 0) model_clear();
    if (exp_hit) begin
      check({name, "_hit_latency"}, 64'(cyc), 64'd3);
      check({name, "_hit_no_sdr"}, 64'(sdr_count - sdr_before), 64'd0);
      exp_data = m_data[idx];
    end else begin
      check({name, "_miss_one_sdr"}, 64'(sdr_count - sdr_before), 64'd1);
      check({name, "_sdr_addr"}, 64'(cap_addr), 64'(exp_sdr));
      exp_data = last_sdr_data;
      if (fmode != 2) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = exp_data;
      end
    end
    check({name, "_data"}, rom_data, exp_data);
  endtask

  initial begin
    logic [20:0] a;
    int          mode, idx, tg;
    model_clear();

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_rom_ack", 64'(rom_ack), 64'd0);
    check("reset_sdr_req", 64'(sdr_req), 64'd0);
    check("reset_rom_data", rom_data, 64'd0);
    check("reset_sdr_addr", 64'(sdr_addr), 64'd0);

    fixed_en = 1'b1;
    do_req(21'h000040, 0, "cold_miss");
    fixed_en = 1'b0;
    do_req(21'h000040, 0, "repeat_hit");
    do_req(21'h000045, 0, "hit_low_bits_ignored");

    do_req(21'h000240, 0, "conflict_miss");
    do_req(21'h000040, 0, "conflict_refetch");
    do_req(21'h000240, 0, "conflict_evicted");

    pulse_flush();
    do_req(21'h000040, 0, "after_flush");
    do_req(21'h000040, 1, "flush_in_lookup");
    do_req(21'h000040, 0, "hit_after_lookup_flush");

    pulse_flush();
    do_req(21'h000040, 2, "flush_in_fill");
    do_req(21'h000040, 0, "after_fill_flush");

    do_req(21'h1FFFF8, 0, "wrap_addr_miss");
    do_req(21'h1FFFF8, 0, "wrap_addr_hit");
    do_req(21'h1FF1F8, 0, "full_tag_compare");

    // Reset while the SDRAM fetch is outstanding
    do_req(21'h000080, 0, "pre_reset_fill");
    pulse_flush();
    sdr_hold = 1'b1;
    @(posedge clk); #1;
    rom_address = 21'h000080;
    rom_req     = ~rom_req;
    repeat (4) @(posedge clk);
    #1;
    reset   = 1'b1;
    rom_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midfill_rom_ack", 64'(rom_ack), 64'd0);
    check("midfill_sdr_req", 64'(sdr_req), 64'd0);
    check("midfill_rom_data", rom_data, 64'd0);
    check("midfill_sdr_addr", 64'(sdr_addr), 64'd0);
    @(posedge clk); #1;
    check("midfill_sdr_ack", 64'(sdr_ack), 64'd0);
    sdr_hold = 1'b0;
    model_clear();
    do_req(21'h000080, 0, "after_midfill_reset");

    for (int i = 0; i < 60; i++) begin
      idx  = $urandom_range(0, 3);
      tg   = $urandom_range(0, 2);
      a    = 21'((tg << 9) | (idx << 3) | $urandom_range(0, 7));
      mode = 0;
      case ($urandom_range(0, 9))
        0: mode = 1;
        1: mode = (m_valid[idx] && m_tag[idx] == tg) ? 0 : 2;
        2: pulse_flush();
        default: mode = 0;
      endcase
      do_req(a, mode, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
